// File: rtl/counter_sequencer_pkg.sv
// Shared encodings for the counter sequencer: downstream counter modes and
// the sequencer FSM states.
package counter_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_UP1  = 2'b00,
        MODE_DN1  = 2'b01,
        MODE_DN3  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/counter_sequencer.sv
// Command sequencer for a 4-bit up/down/load counter: accepts one command at a
// time, drives mode/D/enable, and reports rco count and final Q of each command.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int CYCW     = 8,
    parameter int LOAD_TMO = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_mode,
    input  logic [3:0]      cmd_data,
    input  logic [CYCW-1:0] cmd_cycles,
    input  logic            abort,
    input  logic            rco,
    input  logic            load,
    input  logic [3:0]      Q,
    output logic [1:0]      mode,
    output logic [3:0]      D,
    output logic            enable,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic            load_err,
    output logic [CYCW-1:0] rco_count,
    output logic [3:0]      last_q
);

    localparam int TMOW = (LOAD_TMO > 1) ? $clog2(LOAD_TMO) : 1;
    localparam logic [TMOW-1:0] TMO_LAST = TMOW'(LOAD_TMO - 1);

    state_e          state;
    logic [CYCW-1:0] cyc_cnt;
    logic [TMOW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mode      <= MODE_UP1;
            D         <= 4'd0;
            enable    <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            aborted   <= 1'b0;
            load_err  <= 1'b0;
            rco_count <= '0;
            last_q    <= 4'd0;
            cyc_cnt   <= '0;
            tmo_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        mode      <= cmd_mode;
                        D         <= cmd_data;
                        rco_count <= '0;
                        aborted   <= 1'b0;
                        load_err  <= 1'b0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        cyc_cnt   <= cmd_cycles;
                        tmo_cnt   <= '0;
                        if (cmd_mode == MODE_LOAD) begin
                            state  <= ST_LOAD;
                            enable <= 1'b1;
                        end else if (cmd_cycles == '0) begin
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_RUN;
                            enable <= 1'b1;
                        end
                    end
                end

                // The load strobe is a single-cycle pulse; afterwards we only
                // wait for the counter's acknowledge or the timeout.
                ST_LOAD: begin
                    enable <= 1'b0;
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= ST_DONE;
                    end else if (load) begin
                        state <= ST_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        load_err <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMOW'(1);
                    end
                end

                ST_RUN: begin
                    if (rco && (rco_count != '1)) begin
                        rco_count <= rco_count + CYCW'(1);
                    end
                    // Final cycle wins over abort so a late abort is a normal finish.
                    if (cyc_cnt == CYCW'(1)) begin
                        enable <= 1'b0;
                        state  <= ST_DONE;
                    end else if (abort) begin
                        enable  <= 1'b0;
                        aborted <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        cyc_cnt <= cyc_cnt - CYCW'(1);
                    end
                end

                ST_DONE: begin
                    done      <= 1'b1;
                    last_q    <= Q;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    enable    <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a behavioural 4-bit counter drives rco/load/Q,
// and a per-command trace model predicts every output on every cycle.
module tb_counter_sequencer;

    localparam int CYCW     = 8;
    localparam int LOAD_TMO = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_mode = 2'd0;
    logic [3:0]      cmd_data = 4'd0;
    logic [CYCW-1:0] cmd_cycles = '0;
    logic            abort = 1'b0;
    logic            rco;
    logic            load;
    logic [3:0]      q_env;
    logic [1:0]      mode;
    logic [3:0]      d_out;
    logic            enable;
    logic            busy;
    logic            done;
    logic            aborted;
    logic            load_err;
    logic [CYCW-1:0] rco_count;
    logic [3:0]      last_q;

    counter_sequencer #(.CYCW(CYCW), .LOAD_TMO(LOAD_TMO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_data(cmd_data), .cmd_cycles(cmd_cycles),
        .abort(abort), .rco(rco), .load(load), .Q(q_env),
        .mode(mode), .D(d_out), .enable(enable),
        .busy(busy), .done(done), .aborted(aborted), .load_err(load_err),
        .rco_count(rco_count), .last_q(last_q)
    );

    always #5 clk = ~clk;

    // Downstream counter environment
    int   tb_abort_at = 0;
    bit   tb_tie0 = 1'b0;
    logic load_pulse;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_env      <= 4'd0;
            load_pulse <= 1'b0;
        end else begin
            load_pulse <= enable && (mode == 2'b11);
            if (enable) begin
                case (mode)
                    2'b00:   q_env <= q_env + 4'd1;
                    2'b01:   q_env <= q_env - 4'd1;
                    2'b10:   q_env <= q_env - 4'd3;
                    default: q_env <= d_out;
                endcase
            end
        end
    end

    assign load = load_pulse && !tb_tie0;
    assign rco  = enable && (((mode == 2'b00) && (q_env == 4'd15)) ||
                             ((mode == 2'b01) && (q_env == 4'd0))  ||
                             ((mode == 2'b10) && (q_env < 4'd3)));

    // Expected-output model
    typedef struct packed {
        logic       busy;
        logic       ready;
        logic       enable;
        logic       done;
        logic       aborted;
        logic       lerr;
        logic [7:0] rcnt;
        logic [3:0] lastq;
        logic [1:0] mode;
        logic [3:0] d_out;
    } obs_t;

    obs_t exp_q[$];
    obs_t exp_v, act_v;
    logic [1:0] p_mode = 2'd0;
    logic [3:0] p_d = 4'd0;
    logic       p_ab = 1'b0;
    logic       p_le = 1'b0;
    int         p_rc = 0;
    logic [3:0] p_lastq = 4'd0;
    int         q_model = 0;

    int n_vec = 0;
    int n_err = 0;
    int en_total = 0;
    int done_total = 0;
    int busy_total = 0;

    task automatic gen_trace(input logic [1:0] m, input logic [3:0] d,
                             input logic [7:0] n, input int a, input bit tie0);
        obs_t e;
        int   rc, q, lc, ncyc, nx, step;
        bit   ab, le;
        ab = 1'b0; le = 1'b0; rc = 0; q = q_model;
        e.busy = 1'b1; e.ready = 1'b0; e.enable = 1'b0; e.done = 1'b0;
        e.aborted = 1'b0; e.lerr = 1'b0; e.rcnt = 8'd0; e.lastq = p_lastq;
        e.mode = m; e.d_out = d;
        if (m == 2'b11) begin
            lc = tie0 ? LOAD_TMO : 2;
            if (a > 0 && a < lc) begin
                lc = a; ab = 1'b1;
            end else if (tie0) begin
                le = 1'b1;
            end
            for (int i = 1; i <= lc; i++) begin
                e.enable = (i == 1);
                exp_q.push_back(e);
            end
            q = int'(d);
        end else if (n != 0) begin
            step = (m == 2'b00) ? 1 : (m == 2'b01) ? -1 : -3;
            ab   = (a > 0) && (a < int'(n));
            ncyc = ab ? a : int'(n);
            for (int j = 1; j <= ncyc; j++) begin
                e.enable = 1'b1;
                e.rcnt   = rc[7:0];
                exp_q.push_back(e);
                nx = q + step;
                if ((nx < 0 || nx > 15) && rc < 255) rc = rc + 1;
                q = (nx + 16) % 16;
            end
        end
        e.enable = 1'b0; e.aborted = ab; e.lerr = le; e.rcnt = rc[7:0];
        exp_q.push_back(e);
        e.busy = 1'b0; e.ready = 1'b1; e.done = 1'b1; e.lastq = q[3:0];
        exp_q.push_back(e);
        p_mode = m; p_d = d; p_ab = ab; p_le = le; p_rc = rc;
        p_lastq = q[3:0]; q_model = q;
    endtask

    always @(posedge clk) begin
        if (reset && cmd_valid && exp_q.size() == 0)
            gen_trace(cmd_mode, cmd_data, cmd_cycles, tb_abort_at, tb_tie0);
    end

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            p_mode = 2'd0; p_d = 4'd0; p_ab = 1'b0; p_le = 1'b0;
            p_rc = 0; p_lastq = 4'd0; q_model = 0;
        end else begin
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
            end else begin
                exp_v.busy = 1'b0; exp_v.ready = 1'b1; exp_v.enable = 1'b0;
                exp_v.done = 1'b0; exp_v.aborted = p_ab; exp_v.lerr = p_le;
                exp_v.rcnt = p_rc[7:0]; exp_v.lastq = p_lastq;
                exp_v.mode = p_mode; exp_v.d_out = p_d;
            end
            act_v.busy = busy; act_v.ready = cmd_ready; act_v.enable = enable;
            act_v.done = done; act_v.aborted = aborted; act_v.lerr = load_err;
            act_v.rcnt = rco_count; act_v.lastq = last_q;
            act_v.mode = mode; act_v.d_out = d_out;
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL cycle_outputs t=%0t actual=%h required=%h (busy,ready,en,done,ab,lerr,rcnt,lastq,mode,D)",
                         $time, act_v, exp_v);
            end
            if (enable) en_total++;
            if (done) done_total++;
            if (busy) busy_total++;
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Issue one command from an idle negedge and return at the negedge where done is seen.
    task automatic run_cmd(input logic [1:0] m, input logic [3:0] d, input logic [7:0] n,
                           input int a, input bit tie0, output int lat);
        int guard;
        tb_abort_at = a; tb_tie0 = tie0;
        cmd_mode = m; cmd_data = d; cmd_cycles = n; cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 300) begin @(negedge clk); guard++; end
        check("accept_timeout", int'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        if (a > 0) begin
            repeat (a - 1) begin @(negedge clk); lat++; end
            abort = 1'b1;
            @(negedge clk);
            lat++;
            abort = 1'b0;
        end
        guard = 0;
        while (!done && guard < 300) begin @(negedge clk); lat++; guard++; end
        check("done_timeout", int'(done), 1);
        $display("cmd mode=%0d data=%0d cycles=%0d abort_at=%0d tie_load0=%0d latency=%0d last_q=%0d rco_count=%0d aborted=%0d load_err=%0d",
                 m, d, n, a, tie0, lat, last_q, rco_count, aborted, load_err);
    endtask

    int lat, en0, dn0, bz0;

    task automatic snap();
        en0 = en_total; dn0 = done_total; bz0 = busy_total;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("reset_cmd_ready", int'(cmd_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_last_q", int'(last_q), 0);
        $display("reset released");

        // Preload counter with 0
        run_cmd(2'b11, 4'd0, 8'd0, 0, 1'b0, lat);
        @(negedge clk);

        // Up by 1, 20 cycles
        snap();
        run_cmd(2'b00, 4'd0, 8'd20, 0, 1'b0, lat);
        @(negedge clk);
        check("up20_enables", en_total - en0, 20);
        check("up20_rco_count", int'(rco_count), 1);
        check("up20_last_q", int'(last_q), 4);
        check("up20_done_pulses", done_total - dn0, 1);
        check("up20_latency", lat, 22);

        // Parallel load of 9 with acknowledge
        snap();
        run_cmd(2'b11, 4'd9, 8'd0, 0, 1'b0, lat);
        @(negedge clk);
        check("load9_enables", en_total - en0, 1);
        check("load9_last_q", int'(last_q), 9);
        check("load9_load_err", int'(load_err), 0);
        check("load9_latency", lat, 4);

        // Load with no acknowledge: timeout
        snap();
        run_cmd(2'b11, 4'd5, 8'd0, 0, 1'b1, lat);
        @(negedge clk);
        check("loadtmo_load_err", int'(load_err), 1);
        check("loadtmo_busy_cycles", busy_total - bz0, 5);
        check("loadtmo_latency", lat, 6);

        // Down by 3, aborted in the 3rd RUN cycle
        snap();
        run_cmd(2'b10, 4'd0, 8'd10, 3, 1'b0, lat);
        @(negedge clk);
        check("dn3abort_enables", en_total - en0, 3);
        check("dn3abort_aborted", int'(aborted), 1);
        check("dn3abort_last_q", int'(last_q), 12);
        check("dn3abort_rco_count", int'(rco_count), 1);
        check("dn3abort_done_pulses", done_total - dn0, 1);

        // Zero-cycle command
        snap();
        run_cmd(2'b01, 4'd3, 8'd0, 0, 1'b0, lat);
        @(negedge clk);
        check("zero_enables", en_total - en0, 0);
        check("zero_latency", lat, 2);
        check("zero_rco_count", int'(rco_count), 0);

        // Abort while idle is ignored
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", int'(busy), 0);
        check("idle_abort_aborted", int'(aborted), 0);
        $display("idle abort pulse applied");

        // Abort coinciding with final RUN cycle
        snap();
        run_cmd(2'b01, 4'd0, 8'd4, 4, 1'b0, lat);
        @(negedge clk);
        check("lastabort_aborted", int'(aborted), 0);
        check("lastabort_enables", en_total - en0, 4);
        check("lastabort_last_q", int'(last_q), 8);

        // Abort during LOAD
        run_cmd(2'b11, 4'd7, 8'd0, 2, 1'b1, lat);
        @(negedge clk);
        check("loadabort_aborted", int'(aborted), 1);
        check("loadabort_load_err", int'(load_err), 0);
        check("loadabort_latency", lat, 4);

        // Second command held off while the first is busy
        snap();
        tb_abort_at = 0; tb_tie0 = 1'b0;
        cmd_mode = 2'b00; cmd_data = 4'd0; cmd_cycles = 8'd5; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_mode = 2'b10; cmd_data = 4'd1; cmd_cycles = 8'd2;
        @(negedge clk);
        begin
            int guard;
            guard = 0;
            while (!cmd_ready && guard < 300) begin @(negedge clk); guard++; end
            check("holdoff_accept", int'(cmd_ready), 1);
            @(negedge clk);
            cmd_valid = 1'b0;
            guard = 0;
            while (!done && guard < 300) begin @(negedge clk); guard++; end
            check("holdoff_done", int'(done), 1);
        end
        @(negedge clk);
        check("holdoff_done_pulses", done_total - dn0, 2);
        check("holdoff_last_q", int'(last_q), 6);
        $display("cmd pair held off: second last_q=%0d", last_q);

        // Reset in the middle of a long RUN
        cmd_mode = 2'b00; cmd_data = 4'd0; cmd_cycles = 8'd50; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("midrun_enable_before", int'(enable), 1);
        #2 reset = 1'b0;
        #1;
        check("midrun_enable_async", int'(enable), 0);
        check("midrun_ready_async", int'(cmd_ready), 1);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("postreset_busy", int'(busy), 0);
        check("postreset_rco_count", int'(rco_count), 0);
        check("postreset_mode", int'(mode), 0);
        check("postreset_last_q", int'(last_q), 0);
        $display("reset applied mid-run and released");

        // Normal operation after reset
        run_cmd(2'b00, 4'd0, 8'd3, 0, 1'b0, lat);
        @(negedge clk);
        check("after_reset_last_q", int'(last_q), 3);
        check("after_reset_latency", lat, 5);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
